// File: rtl/lid_reg_write_source.sv
// Transmitter side of a latency-insensitive VALID/CONSUMED write link: a small
// FIFO whose head is offered as one token on paired data and enable channels.
module lid_reg_write_source #(
  parameter int width = 1,
  parameter int depth = 4
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic [((width > 0) ? width : 1)-1:0] ENQ_DATA,
  input  logic                              ENQ_EN,
  input  logic                              ENQ_VALID,
  output logic                              ENQ_RDY,
  output logic [((width > 0) ? width : 1)-1:0] OUT_WRITE,
  output logic                              OUT_WRITE_VALID,
  input  logic                              OUT_WRITE_CONSUMED,
  output logic                              OUT_EN_WRITE,
  output logic                              OUT_EN_WRITE_VALID,
  input  logic                              OUT_EN_WRITE_CONSUMED,
  output logic [$clog2(depth):0]            COUNT
);

  localparam int DW = (width > 0) ? width : 1;
  localparam int AW = $clog2(depth);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(depth);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_wdone;
  logic             r_edone;
  logic [depth-1:0] r_en_mem;

  logic w_non_empty;
  logic w_enq_fire;
  logic w_whit;
  logic w_ehit;
  logic w_retire;

  assign w_non_empty = (r_count != '0);
  assign ENQ_RDY     = (r_count != FULL_CNT);
  assign w_enq_fire  = ENQ_VALID && ENQ_RDY;
  assign COUNT       = r_count;

  assign OUT_EN_WRITE_VALID = w_non_empty && !r_edone;
  assign OUT_EN_WRITE       = r_en_mem[r_rd_ptr];
  assign w_ehit             = OUT_EN_WRITE_VALID && OUT_EN_WRITE_CONSUMED;

  generate
    if (width > 0) begin : g_data
      logic [DW-1:0] r_data_mem [depth];

      always_ff @(posedge CLK) begin
        if (w_enq_fire) r_data_mem[r_wr_ptr] <= ENQ_DATA;
      end

      assign OUT_WRITE       = r_data_mem[r_rd_ptr];
      assign OUT_WRITE_VALID = w_non_empty && !r_wdone;
      assign w_whit          = OUT_WRITE_VALID && OUT_WRITE_CONSUMED;
    end else begin : g_nodata
      // Enable-only link: the data channel is always "consumed" for any head.
      assign OUT_WRITE       = '0;
      assign OUT_WRITE_VALID = 1'b1;
      assign w_whit          = w_non_empty;
    end
  endgenerate

  assign w_retire = w_non_empty && (r_wdone || w_whit) && (r_edone || w_ehit);

  // Storage is intentionally unreset; only pointers, count and sticky bits are.
  always_ff @(posedge CLK) begin
    if (w_enq_fire) r_en_mem[r_wr_ptr] <= ENQ_EN;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_wdone  <= 1'b0;
      r_edone  <= 1'b0;
    end else begin
      if (w_enq_fire) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_retire)   r_rd_ptr <= r_rd_ptr + AW'(1);

      if (w_enq_fire && !w_retire)      r_count <= r_count + (AW+1)'(1);
      else if (!w_enq_fire && w_retire) r_count <= r_count - (AW+1)'(1);

      // Sticky done bits hold a channel silent until its sibling catches up.
      if (w_retire) begin
        r_wdone <= 1'b0;
        r_edone <= 1'b0;
      end else begin
        r_wdone <= r_wdone | w_whit;
        r_edone <= r_edone | w_ehit;
      end
    end
  end

endmodule

// File: tb/tb_lid_reg_write_source.sv
// Directed bench for lid_reg_write_source (width=8, depth=4).
module tb_lid_reg_write_source;

  logic       CLK;
  logic       RST_N;
  logic [7:0] ENQ_DATA;
  logic       ENQ_EN;
  logic       ENQ_VALID;
  logic       ENQ_RDY;
  logic [7:0] OUT_WRITE;
  logic       OUT_WRITE_VALID;
  logic       OUT_WRITE_CONSUMED;
  logic       OUT_EN_WRITE;
  logic       OUT_EN_WRITE_VALID;
  logic       OUT_EN_WRITE_CONSUMED;
  logic [2:0] COUNT;

  int checks = 0;
  int errors = 0;
  int w_hits = 0;
  int e_hits = 0;
  int base_w;
  int base_e;

  lid_reg_write_source #(.width(8), .depth(4)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .ENQ_DATA(ENQ_DATA),
    .ENQ_EN(ENQ_EN),
    .ENQ_VALID(ENQ_VALID),
    .ENQ_RDY(ENQ_RDY),
    .OUT_WRITE(OUT_WRITE),
    .OUT_WRITE_VALID(OUT_WRITE_VALID),
    .OUT_WRITE_CONSUMED(OUT_WRITE_CONSUMED),
    .OUT_EN_WRITE(OUT_EN_WRITE),
    .OUT_EN_WRITE_VALID(OUT_EN_WRITE_VALID),
    .OUT_EN_WRITE_CONSUMED(OUT_EN_WRITE_CONSUMED),
    .COUNT(COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change at posedge+1, so the negedge sees what the next edge will see.
  always @(negedge CLK) begin
    if (OUT_WRITE_VALID && OUT_WRITE_CONSUMED) w_hits++;
    if (OUT_EN_WRITE_VALID && OUT_EN_WRITE_CONSUMED) e_hits++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0;
    ENQ_DATA = '0;
    ENQ_EN = 1'b0;
    ENQ_VALID = 1'b0;
    OUT_WRITE_CONSUMED = 1'b1;
    OUT_EN_WRITE_CONSUMED = 1'b1;
    #12;
    check("rst_count", COUNT, 0);
    check("rst_wvalid", OUT_WRITE_VALID, 0);
    check("rst_evalid", OUT_EN_WRITE_VALID, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    check("rst_rdy", ENQ_RDY, 1);

    // 1: single token, both channels consuming
    ENQ_DATA = 8'hA5; ENQ_EN = 1'b1; ENQ_VALID = 1'b1;
    step();
    ENQ_VALID = 1'b0;
    check("t1_wvalid", OUT_WRITE_VALID, 1);
    check("t1_evalid", OUT_EN_WRITE_VALID, 1);
    check("t1_data", OUT_WRITE, 8'hA5);
    check("t1_en", OUT_EN_WRITE, 1);
    check("t1_count", COUNT, 1);
    step();
    check("t1_count_after", COUNT, 0);
    check("t1_wvalid_after", OUT_WRITE_VALID, 0);

    // 2: split consumption, enable channel stalls three cycles
    OUT_EN_WRITE_CONSUMED = 1'b0;
    ENQ_DATA = 8'h3C; ENQ_EN = 1'b1; ENQ_VALID = 1'b1;
    base_w = w_hits; base_e = e_hits;
    step();
    ENQ_VALID = 1'b0;
    check("t2_wvalid0", OUT_WRITE_VALID, 1);
    check("t2_evalid0", OUT_EN_WRITE_VALID, 1);
    step();
    check("t2_wvalid1", OUT_WRITE_VALID, 0);
    check("t2_evalid1", OUT_EN_WRITE_VALID, 1);
    check("t2_count1", COUNT, 1);
    step();
    check("t2_wvalid2", OUT_WRITE_VALID, 0);
    check("t2_evalid2", OUT_EN_WRITE_VALID, 1);
    check("t2_data2", OUT_WRITE, 8'h3C);
    OUT_EN_WRITE_CONSUMED = 1'b1;
    step();
    check("t2_count_ret", COUNT, 0);
    check("t2_whits", w_hits - base_w, 1);
    check("t2_ehits", e_hits - base_e, 1);

    // 3: fill while stalled, then drain in order
    OUT_WRITE_CONSUMED = 1'b0;
    OUT_EN_WRITE_CONSUMED = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      ENQ_DATA = 8'(i); ENQ_EN = 1'b1; ENQ_VALID = 1'b1;
      step();
    end
    check("t3_full_rdy", ENQ_RDY, 0);
    check("t3_full_count", COUNT, 4);
    ENQ_DATA = 8'd5;
    step();
    check("t3_no_accept", COUNT, 4);
    check("t3_head1", OUT_WRITE, 1);
    OUT_WRITE_CONSUMED = 1'b1;
    OUT_EN_WRITE_CONSUMED = 1'b1;
    step();
    check("t3_head2", OUT_WRITE, 2);
    check("t3_count_a", COUNT, 3);
    check("t3_rdy_back", ENQ_RDY, 1);
    step();
    ENQ_VALID = 1'b0;
    check("t3_head3", OUT_WRITE, 3);
    check("t3_count_b", COUNT, 3);
    step();
    check("t3_head4", OUT_WRITE, 4);
    check("t3_count_c", COUNT, 2);
    step();
    check("t3_head5", OUT_WRITE, 5);
    check("t3_count_d", COUNT, 1);
    step();
    check("t3_empty", COUNT, 0);

    // 4: steady stream, one token per cycle across pointer wrap
    for (int i = 0; i < 10; i++) begin
      ENQ_DATA = 8'h40 + 8'(i); ENQ_EN = i[0]; ENQ_VALID = 1'b1;
      step();
      check("t4_head", OUT_WRITE, 8'h40 + 8'(i));
      check("t4_en", OUT_EN_WRITE, i[0]);
      check("t4_count", COUNT, 1);
    end
    ENQ_VALID = 1'b0;
    step();
    check("t4_empty", COUNT, 0);

    // 5: idle token (EN=0) still occupies both channels
    ENQ_DATA = 8'hFF; ENQ_EN = 1'b0; ENQ_VALID = 1'b1;
    step();
    ENQ_VALID = 1'b0;
    check("t5_wvalid", OUT_WRITE_VALID, 1);
    check("t5_evalid", OUT_EN_WRITE_VALID, 1);
    check("t5_en", OUT_EN_WRITE, 0);
    check("t5_data", OUT_WRITE, 8'hFF);
    step();
    check("t5_empty", COUNT, 0);

    // 6: asynchronous reset with a half-consumed head and three entries
    OUT_WRITE_CONSUMED = 1'b1;
    OUT_EN_WRITE_CONSUMED = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ENQ_DATA = 8'h70 + 8'(i); ENQ_EN = 1'b1; ENQ_VALID = 1'b1;
      step();
    end
    ENQ_VALID = 1'b0;
    check("t6_pre_count", COUNT, 3);
    check("t6_pre_wvalid", OUT_WRITE_VALID, 0);
    check("t6_pre_evalid", OUT_EN_WRITE_VALID, 1);
    #2;
    RST_N = 1'b0;
    #1;
    check("t6_rst_count", COUNT, 0);
    check("t6_rst_wvalid", OUT_WRITE_VALID, 0);
    check("t6_rst_evalid", OUT_EN_WRITE_VALID, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    OUT_EN_WRITE_CONSUMED = 1'b1;
    step();
    ENQ_DATA = 8'h11; ENQ_EN = 1'b1; ENQ_VALID = 1'b1;
    base_w = w_hits; base_e = e_hits;
    step();
    ENQ_VALID = 1'b0;
    check("t6_wvalid", OUT_WRITE_VALID, 1);
    check("t6_evalid", OUT_EN_WRITE_VALID, 1);
    check("t6_data", OUT_WRITE, 8'h11);
    step();
    check("t6_empty", COUNT, 0);
    check("t6_whits", w_hits - base_w, 1);
    check("t6_ehits", e_hits - base_e, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lid_reg_write_source.md
Name: lid_reg_write_source

Overview:
- Transmitter side of the latency-insensitive VALID/CONSUMED write interface used by the multi-domain register and wire primitives.
- Accepts write requests from a normal-domain valid/ready producer and buffers them in a small FIFO.
- Drives each buffered request as one token on a paired data channel (WRITE) and enable channel (EN_WRITE).
- Retires a token only after both channels report consumption. The channels may consume in different cycles.

Parameters:
width, 1, data width of WRITE channel; 0 means data-less (enable-only) writes
depth, 4, FIFO entries; power of 2, minimum 2

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  reset, asynchronous, active-low
ENQ_DATA  input  max(width,1)  write data from producer
ENQ_EN  input  1  write-enable bit carried with the token (0 = idle token)
ENQ_VALID  input  1  producer offers a request
ENQ_RDY  output  1  FIFO can accept; transfer when ENQ_VALID && ENQ_RDY
OUT_WRITE  output  max(width,1)  head-entry data
OUT_WRITE_VALID  output  1  data channel token offered
OUT_WRITE_CONSUMED  input  1  receiver consumed data channel
OUT_EN_WRITE  output  1  head-entry enable bit
OUT_EN_WRITE_VALID  output  1  enable channel token offered
OUT_EN_WRITE_CONSUMED  input  1  receiver consumed enable channel
COUNT  output  log2(depth)+1  occupied entries

Behaviour:
- Interface: one clock, CLK. Reset is asynchronous and active-low on RST_N.
- Reset state, applied immediately on RST_N low:
  - COUNT=0, rd/wr pointers=0, sticky bits wDone=eDone=0.
  - OUT_WRITE_VALID=0 (width>0), OUT_EN_WRITE_VALID=0, ENQ_RDY=1 once RST_N is high.
  - Storage is not reset. OUT_WRITE and OUT_EN_WRITE are don't-care while their VALID is low.
- Enqueue:
  - ENQ_RDY = (COUNT != depth). There is no same-cycle bypass when full.
  - An accepted request is written at wr pointer and becomes head-visible the next cycle (latency 1 from an empty FIFO).
- Output channels, with nonEmpty = (COUNT != 0):
  - OUT_EN_WRITE_VALID = nonEmpty && !eDone.
  - OUT_WRITE_VALID = nonEmpty && !wDone when width>0. When width==0 it is constant 1 and the data channel counts as consumed every cycle.
  - OUT_WRITE and OUT_EN_WRITE always show the head entry.
- Per-channel consumption:
  - wHit = OUT_WRITE_VALID && OUT_WRITE_CONSUMED (width==0: wHit = nonEmpty).
  - eHit = OUT_EN_WRITE_VALID && OUT_EN_WRITE_CONSUMED.
  - CONSUMED is ignored while the matching VALID is low. Receivers may hold CONSUMED high when idle.
- Retire:
  - retire = nonEmpty && (wDone || wHit) && (eDone || eHit).
  - On retire: pop the head, advance rd pointer with wrap at depth, clear wDone and eDone.
  - Otherwise: wDone <= wDone | wHit, and eDone <= eDone | eHit.
- Once a channel is marked done, its VALID drops until the token retires. Each channel therefore sees exactly one token per entry.
- Simultaneous enqueue and retire: COUNT is unchanged and both pointers advance. This is allowed at any occupancy below full. When full, only retire occurs.
- Pointer wrap: pointers are log2(depth) bits and wrap naturally. COUNT disambiguates full from empty.
- Reset mid-token:
  - Any partially consumed token is discarded and sticky bits clear.
  - The receiver must be reset in the same domain. No token replay is required.
- No combinational path from ENQ_* to OUT_*. The CONSUMED inputs affect only state, not same-cycle VALID.

Test Plan:
1. Reset, then enqueue {DATA=8'hA5, EN=1} with both CONSUMED tied high -> next cycle both VALIDs=1 with OUT_WRITE=A5, OUT_EN_WRITE=1. Retire occurs that cycle and COUNT returns to 0 the cycle after.
2. Split consumption: token 8'h3C, hold OUT_EN_WRITE_CONSUMED=0 for 3 cycles while OUT_WRITE_CONSUMED=1 -> OUT_WRITE_VALID drops after 1 cycle and OUT_EN_WRITE_VALID stays 1. Token retires the cycle EN consumes. Data is delivered exactly once.
3. Fill with depth=4 and receiver stalled (both CONSUMED=0): enqueue 1,2,3,4 -> ENQ_RDY=0 with COUNT=4. Enqueue of 5 is not accepted. After release, tokens emerge in order 1,2,3,4 and 5 enters only once ENQ_RDY returns to 1.
4. Steady stream: enqueue every cycle with receiver always consuming -> throughput 1 token/cycle and COUNT stays at 1. Pointer wrap past depth shows no reorder over 10 tokens.
5. Idle token: enqueue {EN=0, DATA=FF} -> both channels are offered and retire normally with OUT_EN_WRITE=0.
6. Assert RST_N low asynchronously, mid-cycle, while a token has wDone=1 and COUNT=3 -> VALIDs=0 and COUNT=0 immediately without waiting for a clock edge. After release, a new token 8'h11 is delivered with both channels fresh.
